// File: rtl/i2c_req_arbiter_pkg.sv
// Shared I2C types: arbiter state encoding, address/data widths, default timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int I2C_ADDR_W      = 7;
  localparam int I2C_DATA_W      = 8;
  localparam int I2C_TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and master-side signals of the I2C request arbiter.
// Latency: n/a (wiring only).
// Backpressure: m_busy holds the arbiter in ISSUE; requesters wait on gnt.
interface i2c_req_arbiter_if #(
  parameter int NREQ = 4
);
  import i2c_pkg::*;

  logic [NREQ-1:0]            req;
  logic [I2C_ADDR_W*NREQ-1:0] req_addr;
  logic [I2C_DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            done;
  logic [NREQ-1:0]            err;
  logic                       m_start;
  logic [I2C_ADDR_W-1:0]      m_addr;
  logic [I2C_DATA_W-1:0]      m_data;
  logic                       m_busy;
  logic                       m_done;
  logic                       m_nack;

  // arbiter side
  modport slave (
    input  req, req_addr, req_data, m_busy, m_done, m_nack,
    output gnt, done, err, m_start, m_addr, m_data
  );

  // requesters plus I2C master side
  modport master (
    output req, req_addr, req_data, m_busy, m_done, m_nack,
    input  gnt, done, err, m_start, m_addr, m_data
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; any_req flags that winner is meaningful.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  // scan offsets high to low so the smallest offset from ptr is the last to win
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = |req;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one I2C write master between NREQ requesters, with NACK retry and timeout.
// Latency: req -> gnt 1 cycle, -> m_start 2 cycles; m_done -> done/err 1 cycle.
// Backpressure: m_busy stalls the start pulse in ISSUE; losing requesters simply keep req high.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = I2C_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  i2c_req_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t            state, state_nxt;
  logic [IW-1:0]         winner, rr_ptr, pick_idx;
  logic                  pick_any;
  logic [RW-1:0]         retry_cnt;
  logic [TW-1:0]         timer;
  logic [I2C_ADDR_W-1:0] addr_q, addr_sel;
  logic [I2C_DATA_W-1:0] data_q, data_sel;
  logic                  retry_ok, timed_out;
  logic [NREQ-1:0]       gnt_c, done_c, err_c;
  logic                  start_c;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  assign retry_ok  = retry_cnt < RW'(MAX_RETRY);
  // timer counts cycles since the start pulse, so this fires TIMEOUT+1 cycles after it
  assign timed_out = timer == TW'(TIMEOUT);

  // winner's address/data slices, selected with constant bases
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) begin
        addr_sel = bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        data_sel = bus.req_data[i*I2C_DATA_W +: I2C_DATA_W];
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state: m_done beats the timeout when both land in the same WAIT cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_ISSUE;
      ST_ISSUE: if (!bus.m_busy) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.m_done) begin
          if (!bus.m_nack)   state_nxt = ST_DONE;
          else if (retry_ok) state_nxt = ST_ISSUE;
          else               state_nxt = ST_ERR;
        end else if (timed_out) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // outputs: grant spans GRANT..WAIT and drops as done/err pulses
  always_comb begin
    gnt_c   = '0;
    done_c  = '0;
    err_c   = '0;
    start_c = 1'b0;
    unique case (state)
      ST_GRANT, ST_WAIT: gnt_c[winner] = 1'b1;
      ST_ISSUE: begin
        gnt_c[winner] = 1'b1;
        start_c       = !bus.m_busy;
      end
      ST_DONE: done_c[winner] = 1'b1;
      ST_ERR:  err_c[winner]  = 1'b1;
      default: ;
    endcase
  end

  assign bus.gnt     = gnt_c;
  assign bus.done    = done_c;
  assign bus.err     = err_c;
  assign bus.m_start = start_c;
  assign bus.m_addr  = addr_q;
  assign bus.m_data  = data_q;

  // datapath: winner capture, payload latch, retry/timer counters, pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner    <= '0;
      rr_ptr    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (pick_any) winner <= pick_idx;
        ST_GRANT: begin
          addr_q    <= addr_sel;
          data_q    <= data_sel;
          retry_cnt <= '0;
        end
        ST_ISSUE: if (!bus.m_busy) timer <= TW'(1);
        ST_WAIT: begin
          timer <= timer + TW'(1);
          if (bus.m_done && bus.m_nack && retry_ok) retry_cnt <= retry_cnt + RW'(1);
        end
        ST_DONE, ST_ERR: rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboarded bench for the I2C request arbiter with a behavioural I2C master.
// Latency: n/a.
// Backpressure: m_busy driven directly by the busy scenario.
module tb_i2c_req_arbiter;
  import i2c_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXR = 2;
  localparam int TO   = 1023;

  logic clk = 1'b0;
  logic rst;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_req_arbiter #(.NREQ(NREQ), .MAX_RETRY(MAXR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        is_err;
    int        idx;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  int   gnt_cyc_log[$];
  int   end_cyc_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int starts   = 0;
  int ends     = 0;
  int last_start_cyc = 0;
  int last_end_cyc   = 0;
  int last_mdone_cyc = 0;
  int end_lat        = 0;

  int mm_delay  = 5;
  int mm_nacks  = 0;
  int countdown = 0;
  bit mm_silent = 1'b0;

  logic [6:0] a_tab[NREQ];
  logic [7:0] d_tab[NREQ];
  logic [NREQ-1:0] prev_gnt = '0;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic exp_t mk(input bit e, input int i);
    exp_t x;
    x.is_err = e;
    x.idx    = i;
    x.addr   = a_tab[i];
    x.data   = d_tab[i];
    return x;
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*7 +: 7] = a_tab[i];
      bus.req_data[i*8 +: 8] = d_tab[i];
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ends(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nedge();
      if (ends >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.m_busy = 1'b0;
    bus.m_done = 1'b0;
    bus.m_nack = 1'b0;
    exp_q.delete();
    countdown = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor / scoreboard checker, then the I2C master model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.gnt != 0 && prev_gnt == 0) begin
        gnt_log.push_back(onehot_idx(bus.gnt));
        gnt_cyc_log.push_back(cyc);
      end
      prev_gnt = bus.gnt;
      if (bus.m_start) begin
        starts++;
        last_start_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL start_unexpected: m_start seen at cycle %0d, required none", cyc);
        end else if (bus.m_addr !== exp_q[0].addr || bus.m_data !== exp_q[0].data ||
                     bus.gnt !== (NREQ'(1) << exp_q[0].idx)) begin
          n_fail++;
          $display("FAIL start_payload: got addr=%h data=%h gnt=%b, required addr=%h data=%h gnt=%b",
                   bus.m_addr, bus.m_data, bus.gnt, exp_q[0].addr, exp_q[0].data,
                   NREQ'(1) << exp_q[0].idx);
        end
      end
      if (bus.done != 0 || bus.err != 0) begin
        exp_t e;
        logic [NREQ-1:0] ed, ee;
        ends++;
        last_end_cyc = cyc;
        end_lat = cyc - last_start_cyc;
        end_cyc_log.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL end_unexpected: done=%b err=%b, required no pulse", bus.done, bus.err);
        end else begin
          e  = exp_q.pop_front();
          ed = e.is_err ? '0 : (NREQ'(1) << e.idx);
          ee = e.is_err ? (NREQ'(1) << e.idx) : '0;
          if (bus.done !== ed || bus.err !== ee || bus.gnt !== '0) begin
            n_fail++;
            $display("FAIL end_pulse: got done=%b err=%b gnt=%b, required done=%b err=%b gnt=0000",
                     bus.done, bus.err, bus.gnt, ed, ee);
          end
        end
      end
      if (bus.m_done) begin
        bus.m_done = 1'b0;
        bus.m_nack = 1'b0;
      end
      if (bus.m_start && !mm_silent) begin
        countdown = mm_delay;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.m_done = 1'b1;
          bus.m_nack = (mm_nacks > 0);
          if (mm_nacks > 0) mm_nacks--;
          last_mdone_cyc = cyc;
        end
      end
    end else begin
      prev_gnt = '0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_nack = 1'b0;
    nedge();
    n_checks++;
    if (bus.gnt !== 0 || bus.done !== 0 || bus.err !== 0 || bus.m_start !== 0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b done=%b err=%b start=%b, required all 0",
               bus.gnt, bus.done, bus.err, bus.m_start);
    end
    n_checks++;
    if (bus.m_addr !== 0 || bus.m_data !== 0) begin
      n_fail++;
      $display("FAIL reset_payload: addr=%h data=%h, required 0", bus.m_addr, bus.m_data);
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_single();
    int c0, s0, e0;
    bit ok;
    mm_delay = 20; mm_nacks = 0; mm_silent = 1'b0;
    s0 = starts; e0 = ends;
    for (int i = 0; i < NREQ; i++) begin a_tab[i] = 7'($urandom); d_tab[i] = 8'($urandom); end
    a_tab[1] = 7'h48; d_tab[1] = 8'hA5;
    drive_slots();
    @(posedge clk); #2;
    bus.req = 4'b0010;
    c0 = cyc;
    exp_q.push_back(mk(1'b0, 1));
    nedge();
    n_checks++;
    if (bus.gnt !== 4'b0000) begin
      n_fail++; $display("FAIL single_cyc0_gnt: got %b, required 0000", bus.gnt);
    end
    nedge();
    n_checks++;
    if (bus.gnt !== 4'b0010 || bus.m_start !== 1'b0) begin
      n_fail++; $display("FAIL single_cyc1: gnt=%b start=%b, required gnt=0010 start=0", bus.gnt, bus.m_start);
    end
    @(posedge clk); #2;
    bus.req = '0;
    a_tab[1] = 7'h11; d_tab[1] = 8'h22;
    drive_slots();
    nedge();
    n_checks++;
    if (bus.m_start !== 1'b1 || bus.m_addr !== 7'h48 || bus.m_data !== 8'hA5 || cyc - c0 != 2) begin
      n_fail++;
      $display("FAIL single_cyc2: start=%b addr=%h data=%h cycle=%0d, required 1/48/A5 at cycle 2",
               bus.m_start, bus.m_addr, bus.m_data, cyc - c0);
    end
    wait_ends(e0 + 1, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_wait: ends=%0d, required %0d", ends, e0 + 1); end
    n_checks++;
    if (last_end_cyc != last_mdone_cyc + 1 || last_mdone_cyc != c0 + 22) begin
      n_fail++;
      $display("FAIL single_timing: m_done at %0d end at %0d, required m_done at %0d end at %0d",
               last_mdone_cyc - c0, last_end_cyc - c0, 22, 23);
    end
    n_checks++;
    if (starts - s0 != 1) begin n_fail++; $display("FAIL single_starts: got %0d, required 1", starts - s0); end
  endtask

  task automatic test_round_robin();
    int g0, ec0, s0, e0;
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    mm_delay = 3; mm_nacks = 0; mm_silent = 1'b0;
    for (int i = 0; i < NREQ; i++) begin a_tab[i] = 7'(7'h20 + i); d_tab[i] = 8'(8'hC0 + i); end
    drive_slots();
    g0 = gnt_log.size(); ec0 = end_cyc_log.size(); s0 = starts; e0 = ends;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, order[i]));
    @(posedge clk); #2;
    bus.req = 4'b1111;
    wait_ends(e0 + 5, 300, ok);
    @(posedge clk); #2;
    bus.req = '0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_wait: ends=%0d, required %0d", ends - e0, 5); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (gnt_log.size() <= g0 + i || gnt_log[g0 + i] != order[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d", i,
                 (gnt_log.size() > g0 + i) ? gnt_log[g0 + i] : -1, order[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (gnt_cyc_log.size() <= g0 + i || end_cyc_log.size() <= ec0 + i - 1 ||
          gnt_cyc_log[g0 + i] != end_cyc_log[ec0 + i - 1] + 2) begin
        n_fail++;
        $display("FAIL rr_regrant_gap[%0d]: grant did not follow previous end by 2 cycles", i);
      end
    end
    repeat (6) nedge();
    n_checks++;
    if (starts - s0 != 5 || ends - e0 != 5) begin
      n_fail++; $display("FAIL rr_counts: starts=%0d ends=%0d, required 5 and 5", starts - s0, ends - e0);
    end
  endtask

  task automatic one_nack_run(input int nacks, input bit expect_err, input string nm);
    int s0, e0;
    bit ok;
    mm_delay = 4; mm_nacks = nacks; mm_silent = 1'b0;
    s0 = starts; e0 = ends;
    exp_q.push_back(mk(expect_err, 2));
    @(posedge clk); #2;
    bus.req = 4'b0100;
    nedge(); nedge();
    @(posedge clk); #2;
    bus.req = '0;
    wait_ends(e0 + 1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_wait: no end pulse, required one", nm); end
    n_checks++;
    if (starts - s0 != 3) begin n_fail++; $display("FAIL %s_starts: got %0d, required 3", nm, starts - s0); end
  endtask

  task automatic test_nack_retry();
    for (int i = 0; i < NREQ; i++) begin a_tab[i] = 7'($urandom); d_tab[i] = 8'($urandom); end
    drive_slots();
    one_nack_run(3, 1'b1, "nack3");
    one_nack_run(2, 1'b0, "nack2");
  endtask

  task automatic test_timeout();
    int e0;
    bit ok;
    mm_silent = 1'b1; mm_nacks = 0;
    e0 = ends;
    exp_q.push_back(mk(1'b1, 0));
    exp_q.push_back(mk(1'b0, 2));
    @(posedge clk); #2;
    bus.req = 4'b0001;
    nedge(); nedge();
    @(posedge clk); #2;
    bus.req = 4'b0100;
    wait_ends(e0 + 1, TO + 50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_wait: no err pulse, required one"); end
    n_checks++;
    if (end_lat != TO + 1) begin
      n_fail++; $display("FAIL timeout_latency: err %0d cycles after m_start, required %0d", end_lat, TO + 1);
    end
    mm_silent = 1'b0; mm_delay = 5;
    wait_ends(e0 + 2, 100, ok);
    @(posedge clk); #2;
    bus.req = '0;
    n_checks++;
    if (!ok || gnt_log[$] != 2) begin
      n_fail++; $display("FAIL timeout_next: last grant %0d, required 2", gnt_log[$]);
    end
  endtask

  task automatic test_busy();
    int c0, s0, e0;
    bit ok;
    mm_delay = 5; mm_nacks = 0; mm_silent = 1'b0;
    s0 = starts; e0 = ends;
    exp_q.push_back(mk(1'b0, 1));
    @(posedge clk); #2;
    bus.m_busy = 1'b1;
    bus.req = 4'b0010;
    c0 = cyc;
    for (int k = 0; k < 12; k++) begin
      nedge();
      if (k >= 2) begin
        n_checks++;
        if (bus.m_start !== 1'b0 || bus.gnt !== 4'b0010) begin
          n_fail++; $display("FAIL busy_hold[%0d]: start=%b gnt=%b, required 0 and 0010", k, bus.m_start, bus.gnt);
        end
      end
    end
    @(posedge clk); #2;
    bus.m_busy = 1'b0;
    bus.req = '0;
    nedge();
    n_checks++;
    if (bus.m_start !== 1'b1 || cyc - c0 != 12) begin
      n_fail++; $display("FAIL busy_release: start=%b at cycle %0d, required 1 at 12", bus.m_start, cyc - c0);
    end
    wait_ends(e0 + 1, 100, ok);
    n_checks++;
    if (!ok || starts - s0 != 1) begin
      n_fail++; $display("FAIL busy_single_start: starts=%0d, required 1", starts - s0);
    end
  endtask

  task automatic test_reset_in_wait();
    int e0;
    bit ok;
    mm_delay = 50; mm_nacks = 0; mm_silent = 1'b0;
    exp_q.push_back(mk(1'b0, 2));
    @(posedge clk); #2;
    bus.req = 4'b0100;
    repeat (5) nedge();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt !== 0 || bus.done !== 0 || bus.err !== 0 || bus.m_start !== 0) begin
      n_fail++; $display("FAIL rstwait_ctrl: gnt=%b done=%b err=%b start=%b, required 0",
                         bus.gnt, bus.done, bus.err, bus.m_start);
    end
    n_checks++;
    if (bus.m_addr !== 0 || bus.m_data !== 0) begin
      n_fail++; $display("FAIL rstwait_payload: addr=%h data=%h, required 0", bus.m_addr, bus.m_data);
    end
    exp_q.delete();
    countdown = 0;
    bus.m_done = 1'b0; bus.m_nack = 1'b0;
    mm_delay = 5;
    e0 = ends;
    bus.req = 4'b1010;
    exp_q.push_back(mk(1'b0, 1));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_ends(e0 + 1, 100, ok);
    @(posedge clk); #2;
    bus.req = '0;
    n_checks++;
    if (!ok || gnt_log[$] != 1) begin
      n_fail++; $display("FAIL rstwait_restart: grant %0d, required 1", gnt_log[$]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nack_retry();
    test_timeout();
    test_busy();
    test_reset_in_wait();
    repeat (4) nedge();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected: %0d entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
